// File: rtl/uigr_led_pkg.sv
// rtl/uigr_led_pkg.sv - shared pattern codes and sequencer FSM encoding
package uigr_led_pkg;

  localparam logic [3:0] PAT_OFF          = 4'b0000;
  localparam logic [3:0] PAT_GREEN        = 4'b0001;
  localparam logic [3:0] PAT_RED          = 4'b0010;
  localparam logic [3:0] PAT_YELLOW       = 4'b0011;
  localparam logic [3:0] PAT_SWEEP        = 4'b0100;
  localparam logic [3:0] PAT_BLINK_GREEN  = 4'b0101;
  localparam logic [3:0] PAT_BLINK_RED    = 4'b0110;
  localparam logic [3:0] PAT_BLINK_YELLOW = 4'b0111;
  localparam logic [3:0] PAT_FLASH_GREEN  = 4'b1000;
  localparam logic [3:0] PAT_FLASH_RED    = 4'b1001;
  localparam logic [3:0] PAT_FLASH_YELLOW = 4'b1010;

  // Pattern presented to the driver out of reset.
  localparam logic [3:0] PAT_RESET = PAT_YELLOW;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/uigr_led_req_fifo.sv
// rtl/uigr_led_req_fifo.sv - request queue, power-of-two depth, head visible combinationally
module uigr_led_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uigr_led_sequencer.sv
// rtl/uigr_led_sequencer.sv - queues LED pattern requests and hands them one at a time to the LED driver
module uigr_led_sequencer
  import uigr_led_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_pattern,
  output logic       req_ready,
  output logic [3:0] drv_pattern,
  output logic       drv_start,
  input  logic       drv_busy,
  input  logic       ovf_clr,
  output logic       overflow,
  output logic       ack_err,
  output logic       seq_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          pop;
  logic          ack_set;
  logic          fifo_full;
  logic          fifo_empty;
  logic [3:0]    fifo_head;
  logic [AW:0]   fifo_count;
  logic          push;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign drv_start = (state == ST_START);
  assign seq_busy  = (state != ST_IDLE) || !fifo_empty;

  uigr_led_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (req_pattern),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ack_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !drv_busy) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (drv_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          ack_set   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (!drv_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Sticky flags: a set event in the same cycle as ovf_clr keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      drv_pattern <= PAT_RESET;
      overflow    <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (state == ST_WAIT_ACK) ? tmo_cnt + TW'(1) : '0;
      if (pop) drv_pattern <= fifo_head;
      if (req_valid && !req_ready) overflow <= 1'b1;
      else if (ovf_clr)            overflow <= 1'b0;
      if (ack_set)      ack_err <= 1'b1;
      else if (ovf_clr) ack_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uigr_led_sequencer.sv
// tb/tb_uigr_led_sequencer.sv - directed-vector bench for uigr_led_sequencer
module tb_uigr_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_pattern;
  logic       req_ready;
  logic [3:0] drv_pattern;
  logic       drv_start;
  logic       drv_busy;
  logic       ovf_clr;
  logic       overflow;
  logic       ack_err;
  logic       seq_busy;

  int vectors  = 0;
  int errors   = 0;
  int n_start  = 0;

  uigr_led_sequencer #(
    .FIFO_DEPTH  (4),
    .ACK_TIMEOUT (4)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_pattern (req_pattern),
    .req_ready   (req_ready),
    .drv_pattern (drv_pattern),
    .drv_start   (drv_start),
    .drv_busy    (drv_busy),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow),
    .ack_err     (ack_err),
    .seq_busy    (seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (drv_start === 1'b1) n_start <= n_start + 1;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] p);
    req_valid   = 1'b1;
    req_pattern = p;
    @(negedge clk);
    req_valid   = 1'b0;
  endtask

  task automatic wait_start();
    int w = 0;
    while (drv_start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_vec("start_seen", 32'(drv_start), 1);
  endtask

  // Driver model: raise busy in the START cycle, hold it len cycles, then drop it.
  task automatic serve_one(input int len, output logic [3:0] pat);
    wait_start();
    pat = drv_pattern;
    if (drv_start === 1'b1) begin
      drv_busy = 1'b1;
      repeat (len) @(negedge clk);
      drv_busy = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [3:0] pat;
  logic [3:0] got3 [3];
  logic [3:0] ovf_pats [5];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_pattern = 4'h0; drv_busy = 1'b0; ovf_clr = 1'b0;
    ovf_pats[0] = 4'b0010; ovf_pats[1] = 4'b0011; ovf_pats[2] = 4'b0110;
    ovf_pats[3] = 4'b0111; ovf_pats[4] = 4'b1001;
    repeat (2) @(negedge clk);
    check_vec("rst_ready",    32'(req_ready),   1);
    check_vec("rst_start",    32'(drv_start),   0);
    check_vec("rst_pattern",  32'(drv_pattern), 32'h3);
    check_vec("rst_overflow", 32'(overflow),    0);
    check_vec("rst_ack_err",  32'(ack_err),     0);
    check_vec("rst_seq_busy", 32'(seq_busy),    0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request and latency
    push(4'b0001);
    check_vec("lat_edge_n",   32'(drv_start), 0);
    check_vec("single_busy",  32'(seq_busy),  1);
    @(negedge clk);
    check_vec("lat_edge_n1",  32'(drv_start),   1);
    check_vec("single_pat_l", 32'(drv_pattern), 32'h1);
    serve_one(10, pat);
    check_vec("single_pat",   32'(pat),        32'h1);
    check_vec("single_idle",  32'(seq_busy),   0);
    check_vec("single_nstart", 32'(n_start),   1);
    check_vec("pat_hold",     32'(drv_pattern), 32'h1);

    // Three back-to-back requests
    fork
      begin push(4'b0100); push(4'b0101); push(4'b1000); end
      begin for (int i = 0; i < 3; i++) serve_one(10, got3[i]); end
    join
    check_vec("b2b_0", 32'(got3[0]), 32'h4);
    check_vec("b2b_1", 32'(got3[1]), 32'h5);
    check_vec("b2b_2", 32'(got3[2]), 32'h8);
    check_vec("b2b_nstart", 32'(n_start), 4);

    // Overflow with the driver held busy
    drv_busy = 1'b1;
    for (int i = 0; i < 5; i++) push(ovf_pats[i]);
    check_vec("ovf_ready", 32'(req_ready),           0);
    check_vec("ovf_flag",  32'(overflow),            1);
    check_vec("ovf_count", 32'(u_dut.fifo_count),    4);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_vec("ovf_clr", 32'(overflow), 0);
    drv_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve_one(4, pat);
      check_vec("ovf_drain", 32'(pat), 32'(ovf_pats[i]));
    end
    check_vec("ovf_nstart", 32'(n_start),  8);
    check_vec("ovf_idle",   32'(seq_busy), 0);

    // Ack timeout, then next request is served
    push(4'b0101);
    push(4'b1010);
    check_vec("to_start", 32'(drv_start),   1);
    check_vec("to_pat",   32'(drv_pattern), 32'h5);
    repeat (4) @(negedge clk);
    check_vec("to_early", 32'(ack_err), 0);
    @(negedge clk);
    check_vec("to_flag",  32'(ack_err), 1);
    serve_one(4, pat);
    check_vec("to_next",  32'(pat), 32'ha);
    check_vec("to_nstart", 32'(n_start), 10);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_vec("to_clr", 32'(ack_err), 0);

    // Full queue: pop and push in the same cycle, with ovf_clr also high
    drv_busy = 1'b1;
    push(4'b0010); push(4'b0100); push(4'b0110); push(4'b1000);
    check_vec("full_ready", 32'(req_ready), 0);
    check_vec("full_ovf0",  32'(overflow),  0);
    drv_busy    = 1'b0;
    req_valid   = 1'b1;
    req_pattern = 4'b1111;
    ovf_clr     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    ovf_clr   = 1'b0;
    check_vec("popush_count", 32'(u_dut.fifo_count), 3);
    check_vec("popush_ovf",   32'(overflow),         1);
    check_vec("popush_pat",   32'(drv_pattern),      32'h2);
    serve_one(4, pat);
    check_vec("popush_serve", 32'(pat), 32'h2);

    // Reset during WAIT_DONE with two requests still queued
    wait_start();
    check_vec("mid_pat", 32'(drv_pattern), 32'h4);
    drv_busy = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("mid_count", 32'(u_dut.fifo_count), 2);
    rst_n = 1'b0;
    #1;
    check_vec("mid_rst_start",   32'(drv_start),        0);
    check_vec("mid_rst_pattern", 32'(drv_pattern),      32'h3);
    check_vec("mid_rst_ovf",     32'(overflow),         0);
    check_vec("mid_rst_ack",     32'(ack_err),          0);
    check_vec("mid_rst_busy",    32'(seq_busy),         0);
    check_vec("mid_rst_ready",   32'(req_ready),        1);
    check_vec("mid_rst_count",   32'(u_dut.fifo_count), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    drv_busy = 1'b0;
    repeat (20) @(negedge clk);
    check_vec("post_rst_nstart", 32'(n_start),  12);
    check_vec("post_rst_idle",   32'(seq_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uigr_led_sequencer.md
UIGR_LED_SEQUENCER -- requirements
Module: uigr_led_sequencer

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, request queue depth (power of two, 2..16).
REQ-002 SHALL have parameter: ACK_TIMEOUT, 4, max cycles from drv_start to drv_busy high.
REQ-003 SHALL use one clock and an asynchronous active-low reset; the ports are listed below.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  requester offers req_pattern.
REQ-007 req_pattern  in  4  LED pattern code requested.
REQ-008 req_ready  out  1  queue can accept a request this cycle.
REQ-009 drv_pattern  out  4  pattern code to LED driver pattern input.
REQ-010 drv_start  out  1  one-cycle load pulse to LED driver synchronous start/reset input.
REQ-011 drv_busy  in  1  LED driver busy.
REQ-012 ovf_clr  in  1  clears overflow and ack_err flags.
REQ-013 overflow  out  1  sticky: a request was dropped.
REQ-014 ack_err  out  1  sticky: driver failed to assert busy within ACK_TIMEOUT.
REQ-015 seq_busy  out  1  queue non-empty or FSM not IDLE.

Function
REQ-016 Request SHALL be accepted on a rising clk edge when req_valid and req_ready are both high; accepted codes are queued in FIFO order.
REQ-017 req_ready SHALL equal not-full, derived from the pre-edge count; a simultaneous pop while full SHALL NOT admit a push in that cycle.
REQ-018 req_valid high while req_ready low SHALL set overflow; the request is dropped.
REQ-019 FSM states: IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-020 IDLE: if FIFO non-empty and drv_busy low, pop head into drv_pattern, assert drv_start, go START; if drv_busy high, stay IDLE.
REQ-021 START: drv_start SHALL be high for exactly this one cycle; go WAIT_ACK with timeout counter zeroed.
REQ-022 WAIT_ACK: drv_busy high -> WAIT_DONE; otherwise increment counter; counter reaching ACK_TIMEOUT -> set ack_err, go IDLE.
REQ-023 WAIT_DONE: drv_busy low -> IDLE; no timeout.
REQ-024 Latency: request accepted at edge N into an empty queue with FSM IDLE SHALL produce drv_start high between edges N+1 and N+2.
REQ-025 drv_pattern SHALL hold its last issued value between commands.
REQ-026 ovf_clr SHALL clear overflow and ack_err; a set event in the same cycle wins (flag stays 1).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-028 seq_busy SHALL be low only when FSM is IDLE and the FIFO is empty.

Reset
REQ-029 On rst_n low, asynchronously: FSM IDLE, FIFO empty, drv_start 0, drv_pattern 4'b0011, overflow 0, ack_err 0, seq_busy 0, req_ready 1.
REQ-030 Reset asserted mid-command SHALL discard the queue and the in-flight command; no drv_start SHALL be issued until a new request is accepted after reset release.

Structure
REQ-031 Pattern code constants (solid off/green/red/yellow, sweep, blink, flash codes) and FSM state encoding SHALL live in shared package uigr_led_pkg.
REQ-032 The queue SHALL be a separate sub-module uigr_led_req_fifo (push/pop/full/empty/count, async active-low reset).

Verification
REQ-033 Single request 4'b0001, driver model busy 1 cycle after start for 10 cycles -> one drv_start pulse, drv_pattern=0001, seq_busy low after busy falls.
REQ-034 Push 0100,0101,1000 back-to-back -> three drv_start pulses in that order, each only after drv_busy returns low.
REQ-035 Hold drv_busy high, push 5 requests at DEPTH 4 -> 4 accepted, 5th dropped, overflow=1; ovf_clr -> overflow=0.
REQ-036 Driver model never asserts busy -> ack_err=1 exactly ACK_TIMEOUT cycles after WAIT_ACK entry, FSM serves next queued request.
REQ-037 Full queue, pop and push in same cycle -> push rejected, overflow=1, count=3.
REQ-038 rst_n low during WAIT_DONE with 2 queued -> all outputs at reset values, no drv_start after release without new requests.
